// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 640x480@60 timing constants and helpers
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_CLK_DIV     = 4;
    localparam bit VGA_SYNC_ACTIVE = 1'b0;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    localparam int VGA_H_TOTAL  = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    // Sync windows are half-open: START <= cnt < END.
    localparam int VGA_HS_START = VGA_H_VISIBLE + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int VGA_VS_START = VGA_V_VISIBLE + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    function automatic logic in_window(input logic [COORD_W-1:0] x, input int lo, input int hi);
        return (int'(x) >= lo) && (int'(x) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster position, sync and strobe bundle
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic               pixel_tick;
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               valid;
    logic               hsync;
    logic               vsync;
    logic               line_start;
    logic               frame_start;

    modport master (
        output pixel_tick, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start
    );

    modport slave (
        input pixel_tick, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen_pixel_tick.sv
// rtl/vga_timing_gen_pixel_tick.sv - CLK_DIV enable divider producing the pixel tick
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    // A 1-bit counter parked at 0 gives a constant tick when CLK_DIV is 1.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst || div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == LAST);
endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters with sync, valid and strobe decode
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV     = VGA_CLK_DIV,
    parameter int H_VISIBLE   = VGA_H_VISIBLE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_VISIBLE   = VGA_V_VISIBLE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter bit SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    logic               tick;
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // All decode is straight off the counter registers so it lines up with h_cnt/v_cnt.
    assign vga.pixel_tick  = tick;
    assign vga.h_cnt       = h_cnt;
    assign vga.v_cnt       = v_cnt;
    assign vga.valid       = (int'(h_cnt) < H_VISIBLE) && (int'(v_cnt) < V_VISIBLE);
    assign vga.hsync       = in_window(h_cnt, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vga.vsync       = in_window(v_cnt, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vga.line_start  = tick && (h_cnt == '0);
    assign vga.frame_start = tick && (h_cnt == '0) && (v_cnt == '0);
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces VGA 640x480@60 Hz raster timing from the 100 MHz system clock.
- Drives the pixel-side inputs of the display renderer: valid, h_cnt and v_cnt.
- Drives the board hsync/vsync pins and per-pixel/per-frame strobes for the canvas, UI and mouse pixel sources.
- Contains a pixel-rate enable divider plus horizontal and vertical position counters.

Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz -> 25 MHz); must be >= 1.
- H_VISIBLE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_ACTIVE, 0: level driven on hsync/vsync during the sync pulse (0 = active-low).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous reset, active-high.
- pixel_tick  output  1  one-clk pulse; the counters advance on the clk edge that ends this pulse.
- h_cnt  output  10  current pixel column, 0..H_TOTAL-1.
- v_cnt  output  10  current line, 0..V_TOTAL-1.
- valid  output  1  high when h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
- hsync  output  1  horizontal sync pin.
- vsync  output  1  vertical sync pin.
- line_start  output  1  pulse, coincident with pixel_tick, while h_cnt==0.
- frame_start  output  1  pulse, coincident with pixel_tick, while h_cnt==0 and v_cnt==0.

Behaviour:
- Derived totals:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP = 525.
  - Both must fit in 10 bits.
- Clock and reset:
  - One clock domain, clk only. rst is sampled only on clk rising edges.
  - rst overrides every other action, including mid-line and mid-frame.
  - On rst: div_cnt=0, h_cnt=0, v_cnt=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pixel_tick = (div_cnt==CLK_DIV-1), decoded combinationally.
  - With CLK_DIV=1, pixel_tick is constantly 1.
- Counters, updated only in a cycle where pixel_tick=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments only when h_cnt wraps; at V_TOTAL-1 (with the h wrap) it wraps to 0.
  - Both counters are held between ticks.
- Decode:
  - valid, hsync, vsync, line_start and frame_start are combinational from the registered counters, so zero latency relative to h_cnt/v_cnt.
- Sync windows:
  - hsync = SYNC_ACTIVE when H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC (656..751); otherwise ~SYNC_ACTIVE.
  - vsync = SYNC_ACTIVE when V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC (490..491); otherwise ~SYNC_ACTIVE.
  - vsync is evaluated on v_cnt alone and changes together with the v_cnt update, i.e. at h_cnt 0.
- Strobes:
  - line_start = pixel_tick & (h_cnt==0).
  - frame_start = line_start & (v_cnt==0).
- Values during/just after reset:
  - h_cnt=0, v_cnt=0, valid=1, hsync=1, vsync=1, pixel_tick=0 (CLK_DIV>1).
  - First pixel_tick occurs in the CLK_DIV-th cycle after rst deasserts (cycle 4 for the defaults).
  - frame_start fires on that first tick.
- Periods:
  - Frame period = H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clk.
  - Line period = 3200 clk.
- Renderer timing: consumers sample h_cnt/v_cnt on any clk edge. A pixel value is stable for exactly CLK_DIV clocks.

Decomposition:
- Shared package vga_pkg holds:
  - the eight timing constants;
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - a 10-bit coordinate width constant.
- The renderer and the pixel sources share this package.
- One sub-module: pixel_tick_gen, the parameterised CLK_DIV enable divider with clk/rst in and tick out.
- The counters and decode live in vga_timing_gen.

Test Plan:
- Reset then release:
  - h_cnt=0, v_cnt=0, hsync=1, vsync=1, valid=1 during rst.
  - First pixel_tick occurs exactly 4 clk after release, with frame_start=1 and line_start=1 in that cycle.
- Run one line:
  - hsync low for exactly 96 ticks, starting when h_cnt becomes 656.
  - valid low from h_cnt=640 to 799.
  - h_cnt wraps 799->0 and v_cnt increments 0->1 on the same edge.
- Run one full frame:
  - vsync low exactly while v_cnt is 490..491 (1600 ticks).
  - v_cnt wraps 524->0.
  - Consecutive frame_start pulses are exactly 1,680,000 clk apart.
  - line_start count per frame is 525.
- Mid-frame reset at h_cnt=700, v_cnt=491 (both syncs asserted):
  - Next clk gives h_cnt=0, v_cnt=0, hsync=1, vsync=1.
  - Divider restarts, with the next tick 4 clk after release.
- Reset held across tick boundaries for 10 clk: counters stay 0 and no pixel_tick/frame_start is produced.
- Parameter override CLK_DIV=1, SYNC_ACTIVE=1:
  - pixel_tick constant 1.
  - hsync high only for h_cnt 656..751.
  - Line period 800 clk.
